// File: rtl/gpio_input_port_pkg.sv
// Shared definitions for the GPIO input port: register offsets, reset constants, width mask.
// Register offsets match the cpu_core address decode and the assembler headers.
// Pure definitions: no logic, no timing.
package gpio_input_port_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] GPIO_LEVEL   = 2'd0;
  localparam logic [1:0] GPIO_EVENT   = 2'd1;
  localparam logic [1:0] GPIO_IRQEN   = 2'd2;
  localparam logic [1:0] GPIO_EDGESEL = 2'd3;

  localparam logic [DATA_W-1:0] EVENT_RST   = 8'h00;
  localparam logic [DATA_W-1:0] IRQEN_RST   = 8'h00;
  localparam logic [DATA_W-1:0] EDGESEL_RST = 8'hFF;

  // Ones in the low w bits: marks which register bits have a pin behind them
  function automatic logic [DATA_W-1:0] width_mask(input int w);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_input_port_debounce.sv
// One-bit input conditioner: 2-FF synchroniser, hold-time debounce, change pulse.
// Latency: a clean step reaches lvl_o 2 + DEBOUNCE cycles after it appears on pin_i.
// No backpressure: free-running every cycle; chg_o is a single-cycle pulse.
module gpio_input_port_debounce #(
  parameter int   DEBOUNCE = 1000,
  parameter logic INIT     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic lvl_o,
  output logic lvl_nxt_o,
  output logic chg_o
);

  localparam int CW = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          differ;
  logic          chg;

  // Count consecutive cycles the synchronised input disagrees with the
  // accepted level; accept it on the last one, restart on any agreement.
  always_comb begin
    differ = (sync2_q != lvl_q);
    chg    = differ && (cnt_q == CNT_MAX);
    lvl_d  = chg ? sync2_q : lvl_q;
    cnt_d  = (!differ || chg) ? '0 : cnt_q + CW'(1);
  end

  // Synchroniser chain, accepted level and hold counter
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= INIT;
      sync2_q <= INIT;
      lvl_q   <= INIT;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl_o     = lvl_q;
  assign lvl_nxt_o = sync2_q;
  assign chg_o     = chg;

endmodule

// File: rtl/gpio_input_port.sv
// Memory-mapped GPIO input port: debounced LEVEL, W1C EVENT latch, IRQ_EN, EDGE_SEL, level irq.
// Latency: rdata one cycle after a read address; irq one cycle after EVENT/IRQ_EN change.
// No backpressure: the 6502 bus never stalls; reads and writes complete in one cycle.
module gpio_input_port
  import gpio_input_port_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          DEBOUNCE   = 1000,
  parameter logic [7:0]  INIT_LEVEL = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pins_i,
  input  logic             cs_i,
  input  logic             we_i,
  input  logic [1:0]       addr_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o,
  output logic             irq_o
);

  localparam logic [DATA_W-1:0] WMASK = width_mask(WIDTH);

  logic [WIDTH-1:0]  lvl_w, lvl_nxt_w, chg_w;
  logic [DATA_W-1:0] lvl8, lvl_nxt8, chg8;
  logic [DATA_W-1:0] evt_q, evt_d, evt_set, evt_clr;
  logic [DATA_W-1:0] irqen_q, irqen_d;
  logic [DATA_W-1:0] esel_q, esel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic              wr, rd;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
    gpio_input_port_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .INIT     (INIT_LEVEL[gi])
    ) u_deb (
      .clk       (clk),
      .reset     (reset),
      .pin_i     (pins_i[gi]),
      .lvl_o     (lvl_w[gi]),
      .lvl_nxt_o (lvl_nxt_w[gi]),
      .chg_o     (chg_w[gi])
    );
  end

  // Register file next state: event set beats a same-cycle W1C clear
  always_comb begin
    lvl8                = '0;
    lvl_nxt8            = '0;
    chg8                = '0;
    lvl8[WIDTH-1:0]     = lvl_w;
    lvl_nxt8[WIDTH-1:0] = lvl_nxt_w;
    chg8[WIDTH-1:0]     = chg_w;

    wr = cs_i && we_i;
    rd = cs_i && !we_i;

    evt_set = chg8 & ~(lvl_nxt8 ^ esel_q);
    evt_clr = (wr && addr_i == GPIO_EVENT) ? wdata_i : '0;
    evt_d   = ((evt_q & ~evt_clr) | evt_set) & WMASK;

    irqen_d = (wr && addr_i == GPIO_IRQEN)   ? (wdata_i & WMASK) : irqen_q;
    esel_d  = (wr && addr_i == GPIO_EDGESEL) ? (wdata_i & WMASK) : esel_q;

    irq_d = |(evt_q & irqen_q);

    rdata_d = rdata_q;
    if (rd) begin
      unique case (addr_i)
        GPIO_LEVEL:   rdata_d = lvl8;
        GPIO_EVENT:   rdata_d = evt_q;
        GPIO_IRQEN:   rdata_d = irqen_q;
        GPIO_EDGESEL: rdata_d = esel_q;
        default:      rdata_d = '0;
      endcase
    end
  end

  // Register file, read data and interrupt registers
  always_ff @(posedge clk) begin
    if (reset) begin
      evt_q   <= EVENT_RST;
      irqen_q <= IRQEN_RST;
      esel_q  <= EDGESEL_RST & WMASK;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      evt_q   <= evt_d;
      irqen_q <= irqen_d;
      esel_q  <= esel_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_gpio_input_port.sv
// Bench for gpio_input_port: directed scenarios plus random bus/pin traffic against a behavioural model.
// Model compares rdata/irq every cycle; directed scenarios add fixed-value checks.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_gpio_input_port;

  localparam int         WIDTH      = 6;
  localparam int         DEBOUNCE   = 4;
  localparam logic [7:0] INIT_LEVEL = 8'h00;
  localparam logic [7:0] MASK       = 8'h3F;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] pins;
  logic             cs, we;
  logic [1:0]       addr;
  logic [7:0]       wdata;
  logic [7:0]       rdata;
  logic             irq;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [7:0]       m_ev, m_en, m_es, m_rdata;
  logic             m_irq;
  logic [WIDTH-1:0] m_lvl;
  logic [WIDTH-1:0] m_hist [2];  // [0] pins one edge ago, [1] two edges ago
  int               m_run  [WIDTH];

  gpio_input_port #(
    .WIDTH      (WIDTH),
    .DEBOUNCE   (DEBOUNCE),
    .INIT_LEVEL (INIT_LEVEL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .pins_i  (pins),
    .cs_i    (cs),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .irq_o   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at that edge
  task automatic model_step();
    logic [7:0] lvl8, regv, set, clr;
    if (reset) begin
      m_ev = 8'h00; m_en = 8'h00; m_es = 8'hFF & MASK;
      m_rdata = 8'h00; m_irq = 1'b0;
      m_lvl = INIT_LEVEL[WIDTH-1:0];
      m_hist[0] = INIT_LEVEL[WIDTH-1:0];
      m_hist[1] = INIT_LEVEL[WIDTH-1:0];
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end else begin
      lvl8 = 8'h00;
      lvl8[WIDTH-1:0] = m_lvl;
      case (addr)
        2'd0: regv = lvl8;
        2'd1: regv = m_ev;
        2'd2: regv = m_en;
        default: regv = m_es;
      endcase
      if (cs && !we) m_rdata = regv;
      m_irq = |(m_ev & m_en);
      // A level is accepted once the delayed pin has disagreed for DEBOUNCE edges in a row
      set = 8'h00;
      for (int i = 0; i < WIDTH; i++) begin
        if (m_hist[1][i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEBOUNCE) begin
            m_lvl[i] = m_hist[1][i];
            m_run[i] = 0;
            if (m_hist[1][i] == m_es[i]) set[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      clr = (cs && we && addr == 2'd1) ? wdata : 8'h00;
      m_ev = (m_ev & ~clr) | set;
      if (cs && we && addr == 2'd2) m_en = wdata & MASK;
      if (cs && we && addr == 2'd3) m_es = wdata & MASK;
      m_hist[1] = m_hist[0];
      m_hist[0] = pins;
    end
  endtask

  // One clock: edge, model update, compare outputs just after the edge
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("rdata", rdata, m_rdata);
    chk("irq", irq, m_irq);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic bus_rd(input logic [1:0] a);
    cs = 1'b1; we = 1'b0; addr = a; wdata = 8'h00;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
  endtask

  task automatic bus_idle();
    cs = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00;
  endtask

  initial begin
    reset = 1'b1;
    pins  = '0;
    bus_idle();
    #1;
    run(3);
    reset = 1'b0;

    // Reset state
    chk("t1_rdata", rdata, 8'h00);
    chk("t1_irq", irq, 1'b0);
    bus_rd(2'd3); run(1); chk("t1_edgesel", rdata, 8'h3F);
    bus_rd(2'd2); run(1); chk("t1_irqen", rdata, 8'h00);
    bus_rd(2'd1); run(1); chk("t1_event", rdata, 8'h00);
    bus_rd(2'd0); run(1); chk("t1_level", rdata, 8'h00);

    // Clean rising step on pin 0: accepted on the 6th edge
    pins = 6'h01;
    run(6); chk("t2_level_edge6", rdata, 8'h00);
    run(1); chk("t2_level_edge7", rdata, 8'h01);
    bus_rd(2'd1); run(1); chk("t2_event", rdata, 8'h01);
    chk("t2_irq", irq, 1'b0);

    // Three-cycle glitch on pin 1 is rejected
    pins = 6'h03; run(3);
    pins = 6'h01; run(10);
    bus_rd(2'd0); run(1); chk("t3_level", rdata, 8'h01);
    bus_rd(2'd1); run(1); chk("t3_event", rdata, 8'h01);

    // Falling-edge event on pin 1 with interrupt enabled, then W1C
    bus_wr(2'd1, 8'h01); run(1);
    bus_wr(2'd2, 8'h03); run(1);
    bus_wr(2'd3, 8'hFD); run(1);
    bus_rd(2'd3); run(1); chk("t4_edgesel", rdata, 8'h3D);
    pins = 6'h03; run(8);
    bus_rd(2'd1); run(1); chk("t4_no_rise_evt", rdata, 8'h00);
    pins = 6'h01;
    run(6); chk("t4_evt_edge6", rdata, 8'h00); chk("t4_irq_edge6", irq, 1'b0);
    run(1); chk("t4_evt_edge7", rdata, 8'h02); chk("t4_irq_edge7", irq, 1'b1);
    bus_wr(2'd1, 8'h02); run(1); chk("t4_irq_at_clr", irq, 1'b1);
    bus_idle(); run(1); chk("t4_irq_after_clr", irq, 1'b0);

    // W1C in the same cycle as a new event on bit 0: the event survives
    pins = 6'h00; run(8);
    pins = 6'h01; run(5);
    bus_wr(2'd1, 8'h01); run(1);
    bus_rd(2'd1); run(1); chk("t5_set_wins", rdata, 8'h01);

    // Reset mid-debounce on pin 2, pins held high through and after release
    bus_idle();
    pins = 6'h05; run(4);
    reset = 1'b1; run(1);
    reset = 1'b0;
    bus_rd(2'd1); run(5); chk("t6_no_evt", rdata, 8'h00);
    bus_rd(2'd0); run(1); chk("t6_level_edge6", rdata, 8'h00);
    run(1); chk("t6_level_edge7", rdata, 8'h05);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      int r;
      if ($urandom_range(0, 5) == 0) pins = pins ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
      r = $urandom_range(0, 9);
      cs    = (r < 8);
      we    = (r >= 6);
      addr  = 2'($urandom_range(0, 3));
      wdata = 8'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;
    bus_idle();
    run(2);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
